// File: rtl/pc_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_unit_pkg
// Purpose  : Shared fetch-stage definitions. Holds the default address width,
//            reset vector and sequential increment, plus the next-PC select
//            encoding used by pc_unit.
// Revision : 1.0 - initial release
// ============================================================================
package pc_unit_pkg;

    localparam int              c_XLEN      = 32;
    localparam logic [31:0]     c_RESET_VEC = 32'h0000_0000;
    localparam int              c_INC       = 4;

    // Next-PC source. HOLD is only taken while the fetch stage is stalled.
    typedef enum logic [1:0] {
        SEQ    = 2'd0,
        BRANCH = 2'd1,
        RET    = 2'd2,
        HOLD   = 2'd3
    } pc_sel_e;

endpackage : pc_unit_pkg
`default_nettype wire

// File: rtl/pc_unit_ras.sv
`default_nettype none
// ============================================================================
// Module   : ras_stack
// Purpose  : Circular return-address stack with an occupancy count. A push
//            onto a full stack overwrites the oldest entry; a pop from an
//            empty stack leaves the stack untouched. Both cases raise a
//            one-cycle registered flag.
// Ports    : clk, rst        - clock, asynchronous active-high reset
//            push, pop       - operation strobes (push wins if both set)
//            push_data       - address written on push
//            top_data        - entry at the top pointer
//            count           - number of valid entries (0..RAS_DEPTH)
//            overflow        - pulse: push while full
//            underflow       - pulse: pop while empty
// Revision : 1.0 - initial release
// ============================================================================
module ras_stack #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [XLEN-1:0]              push_data,
    output logic [XLEN-1:0]              top_data,
    output logic [$clog2(RAS_DEPTH):0]   count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int                 c_PTR_W   = $clog2(RAS_DEPTH);
    localparam logic [c_PTR_W:0]   c_CNT_ONE = 1;
    localparam logic [c_PTR_W:0]   c_CNT_MAX = RAS_DEPTH;
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = 1;

    logic [XLEN-1:0]    r_mem [RAS_DEPTH];
    logic [c_PTR_W-1:0] r_top;
    logic [c_PTR_W:0]   r_count;
    logic               r_overflow;
    logic               r_underflow;

    logic [c_PTR_W-1:0] w_top_inc;
    logic               w_full;
    logic               w_empty;

    // Depth is a power of two, so the pointer wraps for free.
    assign w_top_inc = r_top + c_PTR_ONE;
    assign w_full    = (r_count == c_CNT_MAX);
    assign w_empty   = (r_count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_top       <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            if (push) begin
                r_top <= w_top_inc;
                if (w_full) begin
                    // Oldest entry sits at top+1 when full; it is overwritten.
                    r_overflow <= 1'b1;
                end else begin
                    r_count <= r_count + c_CNT_ONE;
                end
            end else if (pop) begin
                if (w_empty) begin
                    r_underflow <= 1'b1;
                end else begin
                    r_top   <= r_top - c_PTR_ONE;
                    r_count <= r_count - c_CNT_ONE;
                end
            end
        end
    end

    // Storage carries no reset; its contents are meaningless until pushed.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            r_mem[w_top_inc] <= push_data;
        end
    end

    assign top_data  = r_mem[r_top];
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule : ras_stack
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_unit
// Purpose  : Fetch-stage program counter with stall hold, branch/jump
//            redirect, call/return via a return-address stack, and target
//            alignment checking. All outputs are registered.
// Ports    : clk, rst        - clock, asynchronous active-high reset
//            stall           - hold PC and RAS, drop requests
//            br_valid        - redirect to br_target (highest priority)
//            br_target       - redirect address
//            br_call         - with br_valid: push pc+INC
//            ret_valid       - pop RAS and jump to popped address
//            pc              - current fetch address
//            ras_count       - valid RAS entries
//            misalign        - pulse: last branch target had low bits set
//            ras_underflow   - pulse: return with empty RAS
//            ras_overflow    - pulse: call with full RAS
// Revision : 1.0 - initial release
// ============================================================================
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int              XLEN      = c_XLEN,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(c_RESET_VEC),
    parameter int              INC       = c_INC,
    parameter int              RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic                         br_valid,
    input  logic [XLEN-1:0]              br_target,
    input  logic                         br_call,
    input  logic                         ret_valid,
    output logic [XLEN-1:0]              pc,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         misalign,
    output logic                         ras_underflow,
    output logic                         ras_overflow
);

    localparam logic [XLEN-1:0] c_INC_V    = XLEN'(INC);
    localparam logic [XLEN-1:0] c_LOW_MASK = XLEN'(INC - 1);

    logic [XLEN-1:0]            r_pc;
    logic                       r_misalign;

    pc_sel_e                    w_sel;
    logic [XLEN-1:0]            w_pc_inc;
    logic [XLEN-1:0]            w_pc_next;
    logic                       w_push;
    logic                       w_pop;
    logic [XLEN-1:0]            w_ras_top;
    logic [$clog2(RAS_DEPTH):0] w_ras_count;

    assign w_pc_inc = r_pc + c_INC_V;

    // A return coinciding with a branch is discarded, so pop is only
    // requested when no branch is present.
    assign w_push = !stall && br_valid && br_call;
    assign w_pop  = !stall && !br_valid && ret_valid;

    always_comb begin
        w_sel = SEQ;
        if (stall) begin
            w_sel = HOLD;
        end else if (br_valid) begin
            w_sel = BRANCH;
        end else if (ret_valid && (w_ras_count != '0)) begin
            w_sel = RET;
        end
    end

    always_comb begin
        w_pc_next = w_pc_inc;
        case (w_sel)
            BRANCH:  w_pc_next = br_target & ~c_LOW_MASK;
            RET:     w_pc_next = w_ras_top;
            HOLD:    w_pc_next = r_pc;
            default: w_pc_next = w_pc_inc;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= RESET_VEC;
            r_misalign <= 1'b0;
        end else begin
            r_pc       <= w_pc_next;
            r_misalign <= (w_sel == BRANCH) && (|(br_target & c_LOW_MASK));
        end
    end

    ras_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_pc_inc),
        .top_data  (w_ras_top),
        .count     (w_ras_count),
        .overflow  (ras_overflow),
        .underflow (ras_underflow)
    );

    assign pc        = r_pc;
    assign ras_count = w_ras_count;
    assign misalign  = r_misalign;

endmodule : pc_unit
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_unit
// Purpose  : Directed self-checking bench for pc_unit. A second instance with
//            a high reset vector exercises address wrap-around.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        br_valid;
    logic [31:0] br_target;
    logic        br_call;
    logic        ret_valid;
    logic [31:0] pc;
    logic [2:0]  ras_count;
    logic        misalign;
    logic        ras_underflow;
    logic        ras_overflow;

    logic        rst2;
    logic        stall2;
    logic        br_valid2;
    logic [31:0] br_target2;
    logic        br_call2;
    logic        ret_valid2;
    logic [31:0] pc2;
    logic [2:0]  ras_count2;
    logic        misalign2;
    logic        ras_underflow2;
    logic        ras_overflow2;

    int checks;
    int errors;

    pc_unit dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .br_valid      (br_valid),
        .br_target     (br_target),
        .br_call       (br_call),
        .ret_valid     (ret_valid),
        .pc            (pc),
        .ras_count     (ras_count),
        .misalign      (misalign),
        .ras_underflow (ras_underflow),
        .ras_overflow  (ras_overflow)
    );

    pc_unit #(.RESET_VEC(32'hFFFF_FFF8)) dut_wrap (
        .clk           (clk),
        .rst           (rst2),
        .stall         (stall2),
        .br_valid      (br_valid2),
        .br_target     (br_target2),
        .br_call       (br_call2),
        .ret_valid     (ret_valid2),
        .pc            (pc2),
        .ras_count     (ras_count2),
        .misalign      (misalign2),
        .ras_underflow (ras_underflow2),
        .ras_overflow  (ras_overflow2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall     = 1'b0;
        br_valid  = 1'b0;
        br_target = 32'h0;
        br_call   = 1'b0;
        ret_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (pc !== 32'h0 || ras_count !== 3'd0 || misalign !== 1'b0 ||
            ras_underflow !== 1'b0 || ras_overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: pc=%h cnt=%0d mis=%b uf=%b of=%b, want 0/0/0/0/0",
                     pc, ras_count, misalign, ras_underflow, ras_overflow);
        end
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++;
            if (pc !== 32'(4 * i)) begin
                errors++;
                $display("FAIL seq_%0d: pc=%h want %h", i, pc, 32'(4 * i));
            end
        end
        // Mid-cycle reset must act without a clock edge.
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (pc !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: pc=%h want 00000000", pc);
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_stall();
        // pc is 0 here; four edges bring it to 0x10.
        for (int i = 0; i < 4; i++) step();
        stall     = 1'b1;
        br_valid  = 1'b1;
        br_target = 32'h80;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (pc !== 32'h10 || misalign !== 1'b0 || ras_underflow !== 1'b0 ||
                ras_overflow !== 1'b0 || ras_count !== 3'd0) begin
                errors++;
                $display("FAIL stall_hold_%0d: pc=%h cnt=%0d pulses=%b%b%b want 10/0/000",
                         i, pc, ras_count, misalign, ras_underflow, ras_overflow);
            end
        end
        idle_inputs();
        step();
        checks++;
        if (pc !== 32'h14) begin
            errors++;
            $display("FAIL stall_release: pc=%h want 00000014", pc);
        end
    endtask

    task automatic test_call_ret();
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (pc !== 32'h20) begin
            errors++;
            $display("FAIL call_setup: pc=%h want 00000020", pc);
        end
        br_valid  = 1'b1;
        br_call   = 1'b1;
        br_target = 32'h102;
        step();
        checks++;
        if (pc !== 32'h100 || misalign !== 1'b1 || ras_count !== 3'd1) begin
            errors++;
            $display("FAIL call_misalign: pc=%h mis=%b cnt=%0d want 100/1/1",
                     pc, misalign, ras_count);
        end
        idle_inputs();
        ret_valid = 1'b1;
        step();
        checks++;
        if (pc !== 32'h24 || ras_count !== 3'd0 || misalign !== 1'b0) begin
            errors++;
            $display("FAIL return: pc=%h cnt=%0d mis=%b want 24/0/0",
                     pc, ras_count, misalign);
        end
        idle_inputs();
        // br_call alone has no effect.
        br_call = 1'b1;
        step();
        checks++;
        if (pc !== 32'h28 || ras_count !== 3'd0) begin
            errors++;
            $display("FAIL call_no_valid: pc=%h cnt=%0d want 28/0", pc, ras_count);
        end
        idle_inputs();
    endtask

    task automatic test_overflow();
        logic [31:0] rets [4];
        rets[0] = 32'h404; rets[1] = 32'h304; rets[2] = 32'h204; rets[3] = 32'h104;
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            br_valid  = 1'b1;
            br_call   = 1'b1;
            br_target = 32'(i * 32'h100);
            step();
            checks++;
            if (pc !== 32'(i * 32'h100) || ras_count !== 3'(i > 4 ? 4 : i) ||
                ras_overflow !== (i == 5)) begin
                errors++;
                $display("FAIL call_%0d: pc=%h cnt=%0d of=%b want %h/%0d/%b",
                         i, pc, ras_count, ras_overflow, 32'(i * 32'h100),
                         (i > 4 ? 4 : i), (i == 5));
            end
        end
        idle_inputs();
        ret_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (pc !== rets[i] || ras_count !== 3'(3 - i) || ras_overflow !== 1'b0) begin
                errors++;
                $display("FAIL ret_%0d: pc=%h cnt=%0d of=%b want %h/%0d/0",
                         i, pc, ras_count, ras_overflow, rets[i], 3 - i);
            end
        end
        idle_inputs();
    endtask

    task automatic test_underflow();
        do_reset();
        for (int i = 0; i < 16; i++) step();
        ret_valid = 1'b1;
        step();
        checks++;
        if (pc !== 32'h44 || ras_underflow !== 1'b1 || ras_count !== 3'd0) begin
            errors++;
            $display("FAIL underflow: pc=%h uf=%b cnt=%0d want 44/1/0",
                     pc, ras_underflow, ras_count);
        end
        idle_inputs();
        br_valid  = 1'b1;
        br_call   = 1'b1;
        br_target = 32'h80;
        step();
        checks++;
        if (pc !== 32'h80 || ras_count !== 3'd1 || ras_underflow !== 1'b0) begin
            errors++;
            $display("FAIL push_one: pc=%h cnt=%0d uf=%b want 80/1/0",
                     pc, ras_count, ras_underflow);
        end
        br_call   = 1'b0;
        br_target = 32'h200;
        ret_valid = 1'b1;
        step();
        checks++;
        if (pc !== 32'h200 || ras_count !== 3'd1) begin
            errors++;
            $display("FAIL br_over_ret: pc=%h cnt=%0d want 200/1", pc, ras_count);
        end
        br_valid = 1'b0;
        step();
        checks++;
        if (pc !== 32'h48 || ras_count !== 3'd0) begin
            errors++;
            $display("FAIL ret_after_br: pc=%h cnt=%0d want 48/0", pc, ras_count);
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        // Pulse must clear when the following cycle is stalled.
        br_valid  = 1'b1;
        br_target = 32'h301;
        step();
        checks++;
        if (pc !== 32'h300 || misalign !== 1'b1) begin
            errors++;
            $display("FAIL mis_pulse: pc=%h mis=%b want 300/1", pc, misalign);
        end
        stall = 1'b1;
        step();
        checks++;
        if (pc !== 32'h300 || misalign !== 1'b0) begin
            errors++;
            $display("FAIL mis_clear_stall: pc=%h mis=%b want 300/0", pc, misalign);
        end
        idle_inputs();
    endtask

    task automatic test_wrap();
        rst2 = 1'b0;
        checks++;
        if (pc2 !== 32'hFFFF_FFF8) begin
            errors++;
            $display("FAIL wrap_reset: pc=%h want fffffff8", pc2);
        end
        step();
        checks++;
        if (pc2 !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_pre: pc=%h want fffffffc", pc2);
        end
        step();
        checks++;
        if (pc2 !== 32'h0) begin
            errors++;
            $display("FAIL wrap_zero: pc=%h want 00000000", pc2);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        rst2       = 1'b1;
        stall2     = 1'b0;
        br_valid2  = 1'b0;
        br_target2 = 32'h0;
        br_call2   = 1'b0;
        ret_valid2 = 1'b0;
        idle_inputs();
        test_reset();
        test_stall();
        test_call_ret();
        test_overflow();
        test_underflow();
        test_back_to_back();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pc_unit
`default_nettype wire

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the single-cycle/pipelined core fetch stage. It replaces the fixed 32-bit increment-only counter. It adds a stall hold, branch/jump redirect, a call/return path backed by a circular return-address stack (RAS), and alignment checking. The instruction-memory address comes from `pc`; the decode/execute stages drive the redirect, call and return controls.

## Interface
Parameters:
- `XLEN`, 32, width of PC and all addresses
- `RESET_VEC`, 32'h0000_0000, PC value loaded on reset
- `INC`, 4, sequential increment in bytes (power of two, ≥ 1)
- `RAS_DEPTH`, 4, return-address stack entries (power of two, ≥ 2)

Ports:
- `clk`  in  1  single clock, rising-edge
- `rst`  in  1  reset, asynchronous and active-high
- `stall`  in  1  hold PC and RAS this cycle
- `br_valid`  in  1  redirect PC to `br_target`
- `br_target`  in  XLEN  redirect address
- `br_call`  in  1  qualifies `br_valid`: also push return address
- `ret_valid`  in  1  pop RAS and jump to popped address
- `pc`  out  XLEN  current fetch address, registered
- `ras_count`  out  $clog2(RAS_DEPTH)+1  valid RAS entries, registered
- `misalign`  out  1  one-cycle pulse: last loaded target was misaligned
- `ras_underflow`  out  1  one-cycle pulse: `ret_valid` with empty RAS
- `ras_overflow`  out  1  one-cycle pulse: push with full RAS

## Operation
- Per-edge priority, evaluated only when `stall`=0: `br_valid` > `ret_valid` > sequential.
- Sequential: `pc` <= `pc` + `INC`, computed modulo 2^XLEN, so 0xFFFF_FFFC+4 becomes 0x0000_0000.
- Branch: `pc` <= `br_target` with the low log2(INC) bits forced to 0.
  - `misalign` pulses if any of those bits was 1.
  - If `br_call`=1, `pc`+`INC` is pushed to the RAS.
  - A `ret_valid` asserted in the same cycle is ignored (no pop).
- Return, RAS non-empty: `pc` <= top entry; `ras_count` decrements.
- Return, RAS empty: behaves as sequential; `ras_underflow` pulses; `ras_count` stays 0.
- Push when `ras_count`=RAS_DEPTH: the oldest entry is overwritten (circular buffer); `ras_count` stays RAS_DEPTH; `ras_overflow` pulses.
- RAS storage: `RAS_DEPTH` × XLEN array with a top pointer that wraps modulo RAS_DEPTH. Push writes at top+1; pop reads at top.
- `br_call` without `br_valid` has no effect.
- `stall`=1 overrides everything:
  - `pc`, RAS contents and `ras_count` hold.
  - All pulse outputs are 0 the following cycle.
  - Redirect/return requests presented during the stall are dropped; the requester re-presents them.

## Timing
- Reset (async assert, released synchronously by the system): `pc`=RESET_VEC, `ras_count`=0, top pointer=0, `misalign`=`ras_underflow`=`ras_overflow`=0. RAS array contents are don't-care.
- Reset asserted mid-operation takes effect immediately, independent of `clk`. It discards pending pushes and pops.
- Latency: every output updates on the rising edge after the request, so 1 cycle. There is no combinational input-to-output path.
- Pulse outputs are high for exactly the one cycle following the triggering edge.
- The first edge after reset release performs a normal update from RESET_VEC.

## Structure
- A shared core package holds `XLEN`, `RESET_VEC` and `INC` defaults, plus a `pc_sel_e` enum {SEQ, BRANCH, RET, HOLD} used for the next-PC select.
- One sub-module is natural: `ras_stack`, parametrised on `XLEN` and `RAS_DEPTH`.
  - Inputs: push, pop, push data.
  - Outputs: top data, count, overflow, underflow.
  - It is a circular buffer with count.
- `pc_unit` contains the next-PC select, the alignment check and the PC register.

## Test plan
- Reset, then 4 free-running edges -> `pc` = 0, 4, 8, 12, 16. Assert `rst` between edges -> `pc`=0 immediately.
- `pc`=0x10, `stall`=1 for 3 cycles with `br_valid`=1, `br_target`=0x80 -> `pc` stays 0x10, no pulses. Release -> `pc`=0x14.
- `pc`=0x20, `br_valid`=1, `br_call`=1, `br_target`=0x102 -> `pc`=0x100, `misalign`=1, `ras_count`=1. Then `ret_valid` -> `pc`=0x24, `ras_count`=0.
- With RAS_DEPTH=4: 5 nested calls from 0x0, 0x100, 0x200, 0x300, 0x400 -> fifth call gives `ras_overflow`=1, `ras_count`=4. Then 4 returns -> 0x404, 0x304, 0x204, 0x104.
- `ras_count`=0, `pc`=0x40, `ret_valid`=1 -> `pc`=0x44, `ras_underflow`=1. Simultaneous `br_valid` (target 0x200) and `ret_valid` with 1 entry -> `pc`=0x200, `ras_count` stays 1.
- RESET_VEC=0xFFFF_FFF8 -> after two edges `pc`=0xFFFF_FFFC, then 0x0000_0000 (wrap).
